// File: rtl/uart_frame_parser.sv
// Host command frame parser: validates 55 AA ADDR OPC LEN PAYLOAD CSUM frames.
// Optional UART_RX_ERR_CNT_EN adds a saturating rejected-frame counter and opcode 0x05.
module uart_frame_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_PAYLOAD    = 8,
    parameter logic [15:0] DEF_TRANS_LEN  = 16'd256,
    parameter logic [15:0] DEF_SMP_RATE   = 16'd1000,
    parameter logic [15:0] DEF_SMP_NUM    = 16'd1024
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_rx_data_valid,
    input  logic [7:0]  I_rx_data,
    input  logic [7:0]  I_device_addr,
    output logic        O_cmd_valid,
    output logic [2:0]  O_cmd_data,
    output logic [15:0] O_trans_length,
    output logic [15:0] O_sampling_rate,
    output logic [15:0] O_sampling_num,
    output logic        O_frame_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [15:0] O_err_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_OPC,
        S_LEN,
        S_PAY,
        S_CSUM,
        S_EXEC
    } state_t;

    state_t        state;
    logic          addr_match;
    logic [7:0]    opcode;
    logic [7:0]    len;
    logic [7:0]    csum;
    logic [15:0]   payload;
    logic [CW-1:0] pay_cnt;
    logic [TW-1:0] tmo_cnt;

    logic          dec_known;
    logic [2:0]    dec_cmd;
    logic [7:0]    dec_len;

    // Opcode table: command code and the exact LEN each opcode requires
    always_comb begin
        dec_known = 1'b0;
        dec_cmd   = 3'd0;
        dec_len   = 8'd0;
        case (opcode)
            8'h01: begin dec_known = 1'b1; dec_cmd = 3'd1; end
            8'h02: begin dec_known = 1'b1; dec_cmd = 3'd2; end
            8'h03: begin dec_known = 1'b1; dec_cmd = 3'd3; end
            8'h04: begin dec_known = 1'b1; dec_cmd = 3'd4; end
`ifdef UART_RX_ERR_CNT_EN
            8'h05: begin dec_known = 1'b1; dec_cmd = 3'd6; end
`endif
            8'h10: begin dec_known = 1'b1; dec_cmd = 3'd5; dec_len = 8'd2; end
            8'h11: begin dec_known = 1'b1; dec_cmd = 3'd5; dec_len = 8'd2; end
            8'h12: begin dec_known = 1'b1; dec_cmd = 3'd5; dec_len = 8'd2; end
            default: ;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state           <= S_IDLE;
            addr_match      <= 1'b0;
            opcode          <= 8'd0;
            len             <= 8'd0;
            csum            <= 8'd0;
            payload         <= 16'd0;
            pay_cnt         <= '0;
            tmo_cnt         <= '0;
            O_cmd_valid     <= 1'b0;
            O_cmd_data      <= 3'd0;
            O_frame_err     <= 1'b0;
            O_trans_length  <= DEF_TRANS_LEN;
            O_sampling_rate <= DEF_SMP_RATE;
            O_sampling_num  <= DEF_SMP_NUM;
`ifdef UART_RX_ERR_CNT_EN
            O_err_cnt       <= 16'd0;
`endif
        end else begin
            O_cmd_valid <= 1'b0;
            O_frame_err <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
            if (O_frame_err && O_err_cnt != 16'hFFFF)
                O_err_cnt <= O_err_cnt + 16'd1;
`endif
            if (state == S_IDLE || state == S_EXEC || I_rx_data_valid)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (state == S_EXEC) begin
                state <= S_IDLE;
                if (dec_known && len == dec_len) begin
                    O_cmd_valid <= 1'b1;
                    O_cmd_data  <= dec_cmd;
                    case (opcode)
                        8'h10: O_trans_length  <= payload;
                        8'h11: O_sampling_rate <= payload;
                        8'h12: O_sampling_num  <= payload;
`ifdef UART_RX_ERR_CNT_EN
                        8'h05: O_err_cnt       <= 16'd0;
`endif
                        default: ;
                    endcase
                end else begin
                    O_frame_err <= 1'b1;
                end
            end else if (state != S_IDLE && tmo_cnt == TMO_LAST) begin
                // Timeout wins over a byte arriving on the same cycle
                state       <= S_IDLE;
                O_frame_err <= 1'b1;
                tmo_cnt     <= '0;
            end else if (I_rx_data_valid) begin
                unique case (state)
                    S_IDLE: begin
                        if (I_rx_data == 8'h55)
                            state <= S_HDR;
                    end
                    S_HDR: begin
                        if (I_rx_data == 8'hAA)
                            state <= S_ADDR;
                        else if (I_rx_data != 8'h55)
                            state <= S_IDLE;
                    end
                    S_ADDR: begin
                        addr_match <= (I_rx_data == I_device_addr);
                        csum       <= I_rx_data;
                        payload    <= 16'd0;
                        state      <= S_OPC;
                    end
                    S_OPC: begin
                        opcode <= I_rx_data;
                        csum   <= csum + I_rx_data;
                        state  <= S_LEN;
                    end
                    S_LEN: begin
                        len  <= I_rx_data;
                        csum <= csum + I_rx_data;
                        if (32'(I_rx_data) > MAX_PAYLOAD) begin
                            O_frame_err <= 1'b1;
                            state       <= S_IDLE;
                        end else if (I_rx_data == 8'd0) begin
                            state <= S_CSUM;
                        end else begin
                            pay_cnt <= I_rx_data[CW-1:0];
                            state   <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        csum    <= csum + I_rx_data;
                        payload <= {payload[7:0], I_rx_data};
                        pay_cnt <= pay_cnt - CW'(1);
                        if (pay_cnt == CW'(1))
                            state <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (I_rx_data != csum) begin
                            O_frame_err <= 1'b1;
                            state       <= S_IDLE;
                        end else if (addr_match) begin
                            state <= S_EXEC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever cmd_valid or frame_err fires.
module tb_uart_frame_parser;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  dev_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_data;
    logic [15:0] trans_len;
    logic [15:0] smp_rate;
    logic [15:0] smp_num;
    logic        frame_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    uart_frame_parser #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .I_clk          (clk),
        .I_rst          (rst),
        .I_rx_data_valid(rx_valid),
        .I_rx_data      (rx_data),
        .I_device_addr  (dev_addr),
        .O_cmd_valid    (cmd_valid),
        .O_cmd_data     (cmd_data),
        .O_trans_length (trans_len),
        .O_sampling_rate(smp_rate),
        .O_sampling_num (smp_num),
        .O_frame_err    (frame_err)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .O_err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [2:0]  cmd;
        logic [15:0] tl;
        logic [15:0] sr;
        logic [15:0] sn;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    logic [7:0]  fr[$];
    logic [15:0] m_tl = 16'd256;
    logic [15:0] m_sr = 16'd1000;
    logic [15:0] m_sn = 16'd1024;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send_bytes();
        foreach (fr[i]) begin
            rx_data  = fr[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
        last_cyc = cyc;
    endtask

    task automatic push(input bit err, input logic [2:0] cmd, input int due);
        exp_t e;
        e.err = err;
        e.cmd = cmd;
        e.tl  = m_tl;
        e.sr  = m_sr;
        e.sn  = m_sn;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && (cmd_valid || frame_err)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got valid=%0b cmd=%0d err=%0b at cyc %0d, required no pulse",
                         cmd_valid, cmd_data, frame_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (frame_err !== e.err || cmd_valid !== !e.err ||
                    (!e.err && cmd_data !== e.cmd) || cyc != e.due ||
                    trans_len !== e.tl || smp_rate !== e.sr || smp_num !== e.sn) begin
                    errors++;
                    $display("FAIL pulse: got err=%0b v=%0b cmd=%0d cyc=%0d tl=%h sr=%h sn=%h, required err=%0b cmd=%0d cyc=%0d tl=%h sr=%h sn=%h",
                             frame_err, cmd_valid, cmd_data, cyc, trans_len, smp_rate, smp_num,
                             e.err, e.cmd, e.due, e.tl, e.sr, e.sn);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        dev_addr = 8'h01;
        gap(3);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_data", 32'(cmd_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_trans_len", 32'(trans_len), 32'd256);
        chk("rst_smp_rate", 32'(smp_rate), 32'd1000);
        chk("rst_smp_num", 32'(smp_num), 32'd1024);
        rst = 1'b0;
        gap(2);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h00, 8'h02};
        send_bytes(); push(0, 3'd1, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h11, 8'h02, 8'h07, 8'hD0, 8'hEB};
        send_bytes(); m_sr = 16'h07D0; push(0, 3'd5, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h00, 8'h03};
        send_bytes(); push(1, 3'd0, last_cyc); gap(4);

        fr = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h00, 8'h03};
        send_bytes(); gap(4);
        fr = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h00, 8'h02};
        send_bytes(); push(0, 3'd1, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h01};
        send_bytes(); push(1, 3'd0, last_cyc + TMO); gap(TMO + 6);
        fr = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h00, 8'h02};
        send_bytes(); push(0, 3'd1, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h04, 8'h00, 8'h05};
        send_bytes(); push(0, 3'd4, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h10, 8'h09};
        send_bytes(); push(1, 3'd0, last_cyc); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h10, 8'h02, 8'h12, 8'h34, 8'h59};
        send_bytes(); m_tl = 16'h1234; push(0, 3'd5, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h02, 8'h00, 8'h40, 8'h55};
        send_bytes(); m_sn = 16'h0040; push(0, 3'd5, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h03};
        send_bytes(); push(0, 3'd2, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h03, 8'h00, 8'h04};
        send_bytes(); push(0, 3'd3, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h01, 8'hAB, 8'hAE};
        send_bytes(); push(1, 3'd0, last_cyc + 1); gap(4);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h20, 8'h00, 8'h21};
        send_bytes(); push(1, 3'd0, last_cyc + 1); gap(4);

`ifdef UART_RX_ERR_CNT_EN
        chk("err_cnt_before_clear", 32'(err_cnt), 32'd5);
`endif
        fr = '{8'h55, 8'hAA, 8'h01, 8'h05, 8'h00, 8'h06};
        send_bytes();
`ifdef UART_RX_ERR_CNT_EN
        push(0, 3'd6, last_cyc + 1); gap(4);
        chk("err_cnt_after_clear", 32'(err_cnt), 32'd0);
`else
        push(1, 3'd0, last_cyc + 1); gap(4);
`endif

        fr = '{8'h55, 8'hAA, 8'h01, 8'h10, 8'h02, 8'h12};
        send_bytes();
        rst = 1'b1;
        gap(1);
        chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_trans_len", 32'(trans_len), 32'd256);
        chk("midrst_smp_rate", 32'(smp_rate), 32'd1000);
        chk("midrst_smp_num", 32'(smp_num), 32'd1024);
        rst  = 1'b0;
        m_tl = 16'd256;
        m_sr = 16'd1000;
        m_sn = 16'd1024;
        gap(2);

        fr = '{8'h55, 8'hAA, 8'h01, 8'h01, 8'h00, 8'h02};
        send_bytes(); push(0, 3'd1, last_cyc + 1); gap(6);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
